// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the clocked SRAM device model.
package sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } sram_cycle_t;

  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;
  localparam int DATA_W  = 16;

endpackage

// File: rtl/sram_responder_if.sv
// SRAM_* control/address pins plus the per-lane DQ drive enables of the device end.
interface sram_responder_if #(
  parameter int ADDR_W = 18
);
  import sram_responder_pkg::*;

  logic [ADDR_W-1:0]      SRAM_ADDR;
  logic                   SRAM_UB_N;
  logic                   SRAM_LB_N;
  logic                   SRAM_WE_N;
  logic                   SRAM_CE_N;
  logic                   SRAM_OE_N;
  logic [LANE_HI:LANE_LO] dq_oe;

  modport master (
    output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
    input  dq_oe
  );

  modport slave (
    input  SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
    output dq_oe
  );

endinterface

// File: rtl/sram_rd_pipe.sv
// Read-return delay line of {valid, data}; valid bits clear asynchronously, data is never reset.
module sram_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] dat_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] dat_out,
  output logic              busy
);

  logic [STAGES-1:0] vld_p;
  logic [DATA_W-1:0] dat_p [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= vld_in;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dat_p[0] <= dat_in;
    for (int i = 1; i < STAGES; i++) dat_p[i] <= dat_p[i-1];
  end

  assign vld_out = vld_p[STAGES-1];
  assign dat_out = dat_p[STAGES-1];
  assign busy    = |vld_p;

endmodule

// File: rtl/sram_responder.sv
// Clocked model of the 256K x 16 async SRAM: lane-masked writes, fixed-latency reads,
// access counters and a sticky flag for CE/WE/OE all asserted together.
module sram_responder #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int MEM_AW = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_responder_if.slave   bus,
  inout  wire [DATA_W-1:0]  SRAM_DQ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic              bus_conflict
);
  import sram_responder_pkg::*;

  localparam int LANE_W = DATA_W / 2;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("sram_responder: RD_LAT must be in 1..4");
  end

  if (ADDR_W > MEM_AW) begin : g_alias
    // Upper address bits are dropped so the array aliases.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.SRAM_ADDR[ADDR_W-1:MEM_AW];
  end

  logic                   ce;
  logic                   wr_cyc;
  logic                   rd_cyc;
  logic                   conflict;
  logic [LANE_HI:LANE_LO] lane_en;
  logic [MEM_AW-1:0]      maddr;

  assign ce       = !bus.SRAM_CE_N;
  assign wr_cyc   = ce && !bus.SRAM_WE_N;
  assign rd_cyc   = ce && bus.SRAM_WE_N && !bus.SRAM_OE_N;
  assign conflict = wr_cyc && !bus.SRAM_OE_N;
  assign lane_en[LANE_LO] = !bus.SRAM_LB_N;
  assign lane_en[LANE_HI] = !bus.SRAM_UB_N;
  assign maddr    = bus.SRAM_ADDR[MEM_AW-1:0];

  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

  always_ff @(posedge clk) begin
    if (rst && wr_cyc) begin
      if (lane_en[LANE_LO]) mem[maddr][LANE_W-1:0]      <= SRAM_DQ[LANE_W-1:0];
      if (lane_en[LANE_HI]) mem[maddr][DATA_W-1:LANE_W] <= SRAM_DQ[DATA_W-1:LANE_W];
    end
  end

  // Stage p0: address sampled and array read on the issue edge.
  logic              vld_p0;
  logic [DATA_W-1:0] dat_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p0 <= 1'b0;
    else      vld_p0 <= rd_cyc;
  end

  always_ff @(posedge clk) begin
    if (rd_cyc) dat_p0 <= mem[maddr];
  end

  // Stages p1..pRD_LAT: return delay; output is valid RD_LAT edges after issue.
  logic              rd_vld;
  logic [DATA_W-1:0] rd_dat;
  logic              pipe_busy;

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_p0),
    .dat_in  (dat_p0),
    .vld_out (rd_vld),
    .dat_out (rd_dat),
    .busy    (pipe_busy)
  );

  // Drive only while the controller is presenting a read cycle right now.
  logic [LANE_HI:LANE_LO] dq_oe;

  assign dq_oe     = {2{rd_vld && rd_cyc}} & lane_en;
  assign bus.dq_oe = dq_oe;

  assign SRAM_DQ[LANE_W-1:0]      = dq_oe[LANE_LO] ? rd_dat[LANE_W-1:0]      : {LANE_W{1'bz}};
  assign SRAM_DQ[DATA_W-1:LANE_W] = dq_oe[LANE_HI] ? rd_dat[DATA_W-1:LANE_W] : {LANE_W{1'bz}};

  sram_cycle_t state_q;
  sram_cycle_t state_nxt;
  logic        wr_inc;
  logic        rd_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    wr_inc    = 1'b0;
    rd_inc    = 1'b0;
    if (wr_cyc) begin
      state_nxt = WRITE;
      wr_inc    = 1'b1;
    end else if (rd_cyc) begin
      state_nxt = READ;
      rd_inc    = 1'b1;
    end else if (!ce && !vld_p0 && !pipe_busy) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count     <= 16'd0;
      rd_count     <= 16'd0;
      bus_conflict <= 1'b0;
    end else begin
      if (wr_inc)   wr_count     <= wr_count + 16'd1;
      if (rd_inc)   rd_count     <= rd_count + 16'd1;
      if (conflict) bus_conflict <= 1'b1;
    end
  end

  ctrl_known_a: assert property (@(posedge clk) disable iff (!rst)
    !bus.SRAM_CE_N |-> !$isunknown({bus.SRAM_WE_N, bus.SRAM_OE_N, bus.SRAM_UB_N, bus.SRAM_LB_N}))
    else $error("sram_responder: unknown control while CE_N=0");

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table plus streaming, discard, conflict and reset sequences.
module tb_sram_responder;

  localparam int RD_LAT = 2;

  logic        clk;
  logic        rst;
  logic [15:0] tb_dq;
  logic        tb_dq_en;
  wire  [15:0] dq;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic        bus_conflict;

  int checks;
  int failures;
  int mwr;
  int mrd;

  sram_responder_if #(.ADDR_W(18)) bus ();

  assign dq = tb_dq_en ? tb_dq : 16'hzzzz;

  sram_responder #(
    .ADDR_W (18),
    .DATA_W (16),
    .MEM_AW (16),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .SRAM_DQ      (dq),
    .wr_count     (wr_count),
    .rd_count     (rd_count),
    .bus_conflict (bus_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [17:0] addr;
    logic [15:0] data;
    logic        ub_n;
    logic        lb_n;
    logic [15:0] exp_dq;
    logic [1:0]  exp_oe;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.SRAM_ADDR = '0;
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_OE_N = 1'b1;
    bus.SRAM_UB_N = 1'b1;
    bus.SRAM_LB_N = 1'b1;
    tb_dq_en      = 1'b0;
  endtask

  task automatic set_read(input logic [17:0] a, input logic ub_n, input logic lb_n);
    bus.SRAM_ADDR = a;
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_OE_N = 1'b0;
    bus.SRAM_UB_N = ub_n;
    bus.SRAM_LB_N = lb_n;
    tb_dq_en      = 1'b0;
  endtask

  task automatic set_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n);
    bus.SRAM_ADDR = a;
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b0;
    bus.SRAM_OE_N = 1'b1;
    bus.SRAM_UB_N = ub_n;
    bus.SRAM_LB_N = lb_n;
    tb_dq         = d;
    tb_dq_en      = 1'b1;
  endtask

  task automatic check_dq(input string name, input logic [15:0] exp, input logic [1:0] exp_oe);
    logic [15:0] mask;
    mask = {{8{exp_oe[1]}}, {8{exp_oe[0]}}};
    check({name, "_oe"}, {30'd0, bus.dq_oe}, {30'd0, exp_oe});
    check({name, "_dq"}, {16'd0, dq & mask}, {16'd0, exp & mask});
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n);
    set_write(a, d, ub_n, lb_n);
    tick();
    set_idle();
    mwr++;
  endtask

  // Issue one read, idle the bus, and peek the drive just before and at the expected latency.
  task automatic do_read(input string name, input logic [17:0] a, input logic ub_n, input logic lb_n,
                         input logic [15:0] exp, input logic [1:0] exp_oe);
    set_read(a, ub_n, lb_n);
    tick();
    set_idle();
    mrd++;
    for (int i = 1; i < RD_LAT; i++) begin
      tick();
      set_read(a, ub_n, lb_n);
      #1;
      check({name, "_early_oe"}, {30'd0, bus.dq_oe}, 32'd0);
      set_idle();
    end
    tick();
    set_read(a, ub_n, lb_n);
    #1;
    check_dq(name, exp, exp_oe);
    set_idle();
    tick();
  endtask

  task automatic check_counts(input string name);
    check({name, "_wr_count"}, {16'd0, wr_count}, mwr);
    check({name, "_rd_count"}, {16'd0, rd_count}, mrd);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mwr      = 0;
    mrd      = 0;
    tb_dq    = '0;
    rst      = 1'b0;
    set_idle();

    vecs[0]  = '{1'b0, 18'h00010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 2'b00, "wr_beef"};
    vecs[1]  = '{1'b1, 18'h00010, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 2'b11, "rd_beef"};
    vecs[2]  = '{1'b0, 18'h00010, 16'h1234, 1'b1, 1'b0, 16'h0000, 2'b00, "wr_lo_lane"};
    vecs[3]  = '{1'b1, 18'h00010, 16'h0000, 1'b0, 1'b0, 16'hBE34, 2'b11, "rd_merged"};
    vecs[4]  = '{1'b1, 18'h00010, 16'h0000, 1'b0, 1'b1, 16'hBE34, 2'b10, "rd_hi_only"};
    vecs[5]  = '{1'b1, 18'h00010, 16'h0000, 1'b1, 1'b0, 16'hBE34, 2'b01, "rd_lo_only"};
    vecs[6]  = '{1'b0, 18'h00007, 16'h5555, 1'b0, 1'b0, 16'h0000, 2'b00, "wr_5555"};
    vecs[7]  = '{1'b1, 18'h10007, 16'h0000, 1'b0, 1'b0, 16'h5555, 2'b11, "rd_alias"};
    vecs[8]  = '{1'b0, 18'h00020, 16'hCAFE, 1'b0, 1'b0, 16'h0000, 2'b00, "wr_cafe"};
    vecs[9]  = '{1'b0, 18'h00020, 16'h00FF, 1'b1, 1'b1, 16'h0000, 2'b00, "wr_no_lane"};
    vecs[10] = '{1'b1, 18'h00020, 16'h0000, 1'b0, 1'b0, 16'hCAFE, 2'b11, "rd_no_lane"};
    vecs[11] = '{1'b0, 18'h00021, 16'h1111, 1'b0, 1'b0, 16'h0000, 2'b00, "wr_1111"};
    vecs[12] = '{1'b0, 18'h00021, 16'hAB22, 1'b0, 1'b1, 16'h0000, 2'b00, "wr_hi_lane"};
    vecs[13] = '{1'b1, 18'h00021, 16'h0000, 1'b0, 1'b0, 16'hAB11, 2'b11, "rd_hi_merge"};

    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_count", {16'd0, wr_count}, 32'd0);
    check("rst_rd_count", {16'd0, rd_count}, 32'd0);
    check("rst_conflict", {31'd0, bus_conflict}, 32'd0);
    check("rst_dq_oe", {30'd0, bus.dq_oe}, 32'd0);
    rst = 1'b1;
    tick();

    for (int v = 0; v < 14; v++) begin
      if (vecs[v].is_rd)
        do_read(vecs[v].name, vecs[v].addr, vecs[v].ub_n, vecs[v].lb_n, vecs[v].exp_dq, vecs[v].exp_oe);
      else
        do_write(vecs[v].addr, vecs[v].data, vecs[v].ub_n, vecs[v].lb_n);
      check_counts(vecs[v].name);
    end

    // Streaming: reads issued on six consecutive edges, data for address k after edge k+2.
    for (int k = 0; k < 4; k++) do_write(18'(k), 16'hA000 + 16'(k), 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      set_read(18'(k % 4), 1'b0, 1'b0);
      tick();
      mrd++;
      if (k >= 2) check_dq($sformatf("stream_e%0d", k), 16'hA000 + 16'(k - 2), 2'b11);
      else        check($sformatf("stream_e%0d_oe", k), {30'd0, bus.dq_oe}, 32'd0);
    end
    set_idle();
    tick();
    tick();
    check_counts("stream");

    // OE_N raised while the read is in flight: never driven, and not held for later.
    set_read(18'h00001, 1'b0, 1'b0);
    tick();
    mrd++;
    bus.SRAM_OE_N = 1'b1;
    for (int i = 0; i < RD_LAT; i++) tick();
    check("oe_high_oe", {30'd0, bus.dq_oe}, 32'd0);
    tick();
    set_read(18'h00001, 1'b0, 1'b0);
    #1;
    check("discard_oe", {30'd0, bus.dq_oe}, 32'd0);
    set_idle();
    tick();
    check_counts("discard");

    // CE, WE and OE all low: behaves as a write and latches the conflict flag.
    check("conflict_pre", {31'd0, bus_conflict}, 32'd0);
    set_write(18'h00030, 16'h7777, 1'b0, 1'b0);
    bus.SRAM_OE_N = 1'b0;
    #1;
    check("conflict_no_drive", {30'd0, bus.dq_oe}, 32'd0);
    tick();
    mwr++;
    check("conflict_set", {31'd0, bus_conflict}, 32'd1);
    set_idle();
    tick();
    tick();
    check("conflict_sticky", {31'd0, bus_conflict}, 32'd1);
    check_counts("conflict");
    do_read("rd_conflict_wr", 18'h00030, 1'b0, 1'b0, 16'h7777, 2'b11);

    // Reset while a read is being driven: release is immediate, memory survives.
    set_read(18'h00010, 1'b0, 1'b0);
    tick();
    set_idle();
    for (int i = 0; i < RD_LAT; i++) tick();
    set_read(18'h00010, 1'b0, 1'b0);
    #1;
    check_dq("pre_reset", 16'hBE34, 2'b11);
    rst = 1'b0;
    #1;
    check("reset_release_oe", {30'd0, bus.dq_oe}, 32'd0);
    check("reset_conflict", {31'd0, bus_conflict}, 32'd0);
    mwr = 0;
    mrd = 0;
    check_counts("reset");
    set_idle();
    tick();
    rst = 1'b1;
    tick();
    do_read("rd_retained", 18'h00010, 1'b0, 1'b0, 16'hBE34, 2'b11);
    check_counts("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
